sha256_round_ctrl: RTL and testbench
====================================

// Module: sha256_round_ctrl
// PURPOSE
//  Sequencer for one SHA-256 compression engine. Accepts 512-bit-block requests and loads the IV into the hash-state registers on a message's first block.
//  Issues load/step/accumulate strobes to the working registers (a..h), message schedule and hash-state (H0..H7) registers.
//  Presents digest_valid after a message's last block. Sits between the block-input interface and the H/a..h register datapath.
// PARAMETERS
//  ROUNDS   64  compression rounds per block (reduced values for simulation only; >=2)
//  IDX_W    6   width of round_idx; must satisfy 2**IDX_W >= ROUNDS
// PORTS
//  clk           in   1      clock, rising edge
//  reset         in   1      asynchronous, active-high
//  blk_valid     in   1      block request; message words are stable on datapath input
//  blk_first     in   1      qualifies blk_valid: first block of message (load IV)
//  blk_last      in   1      qualifies blk_valid: last block of message (emit digest)
//  blk_ready     out  1      controller can accept a block (IDLE only)
//  hv_init       out  1      load H0..H7 with IV (H0=32'h6a09e667 ...)
//  wv_load       out  1      load a..h from H0..H7
//  w_load        out  1      load message schedule W0..W15 from block input
//  wv_step       out  1      perform one round on a..h
//  w_shift       out  1      advance message schedule one word
//  round_idx     out  IDX_W  current round, K-ROM address
//  hv_accum      out  1      H[i] <= H[i] + {a..h}[i], mod 2**32
//  busy          out  1      state != IDLE
//  digest_valid  out  1      H0..H7 hold final digest
//  digest_ready  in   1      consumer takes digest
// BEHAVIOUR
//  - Reset: state=IDLE, round counter=0. All outputs 0 except blk_ready=1. Handshakes are ignored while reset is high.
//  - Reset mid-operation aborts at once to IDLE. H/a..h contents are not touched by this block.
//  - All strobes are Moore-decoded from registered state/counter, with no combinational path from inputs.
//  - States and transitions:
//    IDLE:  blk_ready=1. blk_valid&blk_first -> INIT. blk_valid&!blk_first -> LOAD. blk_first/blk_last are latched at accept.
//    INIT:  hv_init=1, 1 cycle -> LOAD
//    LOAD:  wv_load=1, w_load=1, round_idx=0, 1 cycle -> ROUND
//    ROUND: wv_step=1, w_shift=1 for ROUNDS cycles. round_idx counts 0..ROUNDS-1. At ROUNDS-1 -> ACCUM.
//    ACCUM: hv_accum=1, 1 cycle. Latched last=1 -> OUT; else -> IDLE.
//    OUT:   digest_valid=1, held until digest_ready=1. Then -> IDLE next cycle.
//  - Latency from accept edge (cycle 0), first block: INIT c1, LOAD c2, ROUND c3..c(2+ROUNDS), ACCUM c(3+ROUNDS), OUT/IDLE c(4+ROUNDS).
//  - Non-first blocks are one cycle shorter (no INIT).
//  - blk_valid outside IDLE is ignored; the block is not consumed.
//  - blk_ready is 0 in OUT, so no new block is accepted until the digest is consumed.
//  - digest_ready outside OUT is ignored. digest_ready already high on OUT entry gives a 1-cycle OUT.
//  - Round counter wraps to 0 on leaving ROUND; round_idx=0 outside ROUND.
//  - blk_first&blk_last on one block is legal: single-block message.
// CONFIGURATION
//  - Macro SHA256_CTRL_BLKCNT_EN defined: adds output blk_cnt[31:0].
//    - Cleared to 0 when hv_init is asserted.
//    - +1 on each hv_accum cycle; saturates at 32'hffffffff.
//    - Reset value 0.
//  - Macro not defined: port and counter logic are absent. Behaviour is otherwise identical.
// STRUCTURE
//  - Package sha256_pkg holds:
//    - state typedef {IDLE,INIT,LOAD,ROUND,ACCUM,OUT}
//    - SHA256_ROUNDS=64
//    - SHA256_IDX_W=6
//    - IV constants H0..H7, shared with the hash-state registers
//  - Sub-module sha256_round_cnt: IDX_W counter with clear/enable and a terminal-count flag at ROUNDS-1.
//  - The FSM stays in sha256_round_ctrl.
// TESTING
//  1 Single block, first=last=1, valid at c0, digest_ready=1:
//    -> hv_init c1, wv_load c2, wv_step c3..c66 with round_idx 0..63, hv_accum c67, digest_valid c68, blk_ready=1 c69.
//  2 Two-block message (first, then last):
//    -> one hv_init total. Second block shows wv_load at accept+1. Two hv_accum pulses. One digest_valid.
//  3 Backpressure: digest_ready=0 for 10 cycles in OUT, with blk_valid=1 throughout:
//    -> digest_valid held 10+ cycles, blk_ready=0, no strobe fires.
//  4 Reset asserted at round_idx=30:
//    -> all strobes 0 and round_idx=0 immediately; blk_ready=1 after release.
//    -> the next block restarts at round_idx 0.
//  5 ROUNDS=4 build, single block:
//    -> wv_step exactly 4 cycles (idx 0..3), digest_valid at c8.
//  6 SHA256_CTRL_BLKCNT_EN, 3-block message then a new message:
//    -> blk_cnt reads 3 at first OUT; returns to 0 on the next hv_init.

Source files
------------

// File: rtl/sha256_pkg.sv
// sha256_pkg: shared types and constants for the SHA-256 compression engine.
// Holds the controller state encoding, default round/index sizing and the
// initial hash value (IV) words used by the H0..H7 hash-state registers.
package sha256_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      INIT  = 3'd1,
      LOAD  = 3'd2,
      ROUND = 3'd3,
      ACCUM = 3'd4,
      OUT   = 3'd5
   } state_t;

   localparam int SHA256_ROUNDS = 64;
   localparam int SHA256_IDX_W  = 6;

   localparam logic [31:0] SHA256_H0 = 32'h6a09e667;
   localparam logic [31:0] SHA256_H1 = 32'hbb67ae85;
   localparam logic [31:0] SHA256_H2 = 32'h3c6ef372;
   localparam logic [31:0] SHA256_H3 = 32'ha54ff53a;
   localparam logic [31:0] SHA256_H4 = 32'h510e527f;
   localparam logic [31:0] SHA256_H5 = 32'h9b05688c;
   localparam logic [31:0] SHA256_H6 = 32'h1f83d9ab;
   localparam logic [31:0] SHA256_H7 = 32'h5be0cd19;

   // IV word lookup so the hash-state registers can load H[i] by index.
   function automatic logic [31:0] sha256_iv(input logic [2:0] idx);
      logic [31:0] word;
      case (idx)
         3'd0:    word = SHA256_H0;
         3'd1:    word = SHA256_H1;
         3'd2:    word = SHA256_H2;
         3'd3:    word = SHA256_H3;
         3'd4:    word = SHA256_H4;
         3'd5:    word = SHA256_H5;
         3'd6:    word = SHA256_H6;
         3'd7:    word = SHA256_H7;
         default: word = SHA256_H0;
      endcase
      return word;
   endfunction

endpackage

// File: rtl/sha256_round_cnt.sv
// sha256_round_cnt: round counter for the compression sequencer.
// Counts 0..ROUNDS-1 while enabled, wraps to 0 after the terminal count,
// and is held at 0 by clr. tc flags the last round.
module sha256_round_cnt
   import sha256_pkg::*;
#(
   parameter int ROUNDS = SHA256_ROUNDS,
   parameter int IDX_W  = SHA256_IDX_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             en,
   output logic [IDX_W-1:0] cnt,
   output logic             tc
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);
   localparam logic [IDX_W-1:0] ONE      = IDX_W'(1);

   logic [IDX_W-1:0] cnt_r;
   logic             tc_s;

   assign tc_s = (cnt_r == LAST_IDX);
   assign cnt  = cnt_r;
   assign tc   = tc_s;

   // Round counter: clear has priority, wrap to 0 after the last round.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_r <= '0;
      end else if (clr) begin
         cnt_r <= '0;
      end else if (en) begin
         if (tc_s) begin
            cnt_r <= '0;
         end else begin
            cnt_r <= cnt_r + ONE;
         end
      end else begin
         cnt_r <= cnt_r;
      end
   end

endmodule

// File: rtl/sha256_round_ctrl.sv
// sha256_round_ctrl: sequencer for one SHA-256 compression engine.
// Accepts block requests in IDLE, loads the IV on a message's first block,
// steps the working registers and message schedule for ROUNDS rounds,
// accumulates into H0..H7 and presents digest_valid after the last block.
// All strobes are Moore-decoded from the registered state and round counter.
// Optional feature: define SHA256_CTRL_BLKCNT_EN to add the blk_cnt output,
// a saturating count of accumulated blocks, cleared by hv_init.
module sha256_round_ctrl
   import sha256_pkg::*;
#(
   parameter int ROUNDS = SHA256_ROUNDS,
   parameter int IDX_W  = SHA256_IDX_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             blk_valid,
   input  logic             blk_first,
   input  logic             blk_last,
   output logic             blk_ready,
   output logic             hv_init,
   output logic             wv_load,
   output logic             w_load,
   output logic             wv_step,
   output logic             w_shift,
   output logic [IDX_W-1:0] round_idx,
   output logic             hv_accum,
   output logic             busy,
   output logic             digest_valid,
   input  logic             digest_ready
`ifdef SHA256_CTRL_BLKCNT_EN
   ,
   output logic [31:0]      blk_cnt
`endif
);

   state_t           state_r;
   state_t           state_s;
   logic             last_r;
   logic [IDX_W-1:0] cnt_s;
   logic             tc_s;
   logic             cnt_clr_s;
   logic             cnt_en_s;

   assign cnt_en_s  = (state_r == ROUND);
   assign cnt_clr_s = (state_r != ROUND);

   sha256_round_cnt #(
      .ROUNDS (ROUNDS),
      .IDX_W  (IDX_W)
   ) u_round_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (cnt_clr_s),
      .en    (cnt_en_s),
      .cnt   (cnt_s),
      .tc    (tc_s)
   );

   // State register; reset aborts any block in flight straight to IDLE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Capture the last-block qualifier when a block is accepted.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_r <= 1'b0;
      end else if ((state_r == IDLE) && blk_valid) begin
         last_r <= blk_last;
      end else begin
         last_r <= last_r;
      end
   end

   // Next-state decode.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (blk_valid) begin
               if (blk_first) begin
                  state_s = INIT;
               end else begin
                  state_s = LOAD;
               end
            end else begin
               state_s = IDLE;
            end
         end
         INIT:  state_s = LOAD;
         LOAD:  state_s = ROUND;
         ROUND: begin
            if (tc_s) begin
               state_s = ACCUM;
            end else begin
               state_s = ROUND;
            end
         end
         ACCUM: begin
            if (last_r) begin
               state_s = OUT;
            end else begin
               state_s = IDLE;
            end
         end
         OUT: begin
            if (digest_ready) begin
               state_s = IDLE;
            end else begin
               state_s = OUT;
            end
         end
         default: state_s = IDLE;
      endcase
   end

   // Moore output decode from registered state and round counter.
   always_comb begin
      blk_ready    = 1'b0;
      hv_init      = 1'b0;
      wv_load      = 1'b0;
      w_load       = 1'b0;
      wv_step      = 1'b0;
      w_shift      = 1'b0;
      round_idx    = '0;
      hv_accum     = 1'b0;
      busy         = 1'b1;
      digest_valid = 1'b0;
      case (state_r)
         IDLE: begin
            blk_ready = 1'b1;
            busy      = 1'b0;
         end
         INIT: hv_init = 1'b1;
         LOAD: begin
            wv_load = 1'b1;
            w_load  = 1'b1;
         end
         ROUND: begin
            wv_step   = 1'b1;
            w_shift   = 1'b1;
            round_idx = cnt_s;
         end
         ACCUM: hv_accum = 1'b1;
         OUT:   digest_valid = 1'b1;
         default: begin
            blk_ready = 1'b0;
            busy      = 1'b0;
         end
      endcase
   end

`ifdef SHA256_CTRL_BLKCNT_EN
   logic [31:0] blk_cnt_r;

   assign blk_cnt = blk_cnt_r;

   // Accumulated-block count: cleared at IV load, saturating increment.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         blk_cnt_r <= 32'd0;
      end else if (hv_init) begin
         blk_cnt_r <= 32'd0;
      end else if (hv_accum && (blk_cnt_r != 32'hffff_ffff)) begin
         blk_cnt_r <= blk_cnt_r + 32'd1;
      end else begin
         blk_cnt_r <= blk_cnt_r;
      end
   end
`endif

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// tb_sha256_round_ctrl: directed scoreboard bench for sha256_round_ctrl.
// Two instances: the default 64-round build and a 4-round build.
// Expected per-cycle output vectors are queued when a block is driven and
// popped/compared on each falling edge.
module tb_sha256_round_ctrl;

   localparam int S_IDLE  = 0;
   localparam int S_INIT  = 1;
   localparam int S_LOAD  = 2;
   localparam int S_ROUND = 3;
   localparam int S_ACCUM = 4;
   localparam int S_OUT   = 5;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   // 64-round instance
   logic       a_valid, a_first, a_last, a_dready;
   logic       a_ready, a_hv_init, a_wv_load, a_w_load, a_wv_step, a_w_shift;
   logic       a_hv_accum, a_busy, a_dv;
   logic [5:0] a_idx;
   // 4-round instance
   logic       b_valid, b_first, b_last, b_dready;
   logic       b_ready, b_hv_init, b_wv_load, b_w_load, b_wv_step, b_w_shift;
   logic       b_hv_accum, b_busy, b_dv;
   logic [1:0] b_idx;
`ifdef SHA256_CTRL_BLKCNT_EN
   logic [31:0] a_blk_cnt, b_blk_cnt;
`endif

   sha256_round_ctrl #(.ROUNDS(64), .IDX_W(6)) u_dut (
      .clk(clk), .reset(reset),
      .blk_valid(a_valid), .blk_first(a_first), .blk_last(a_last),
      .blk_ready(a_ready), .hv_init(a_hv_init), .wv_load(a_wv_load),
      .w_load(a_w_load), .wv_step(a_wv_step), .w_shift(a_w_shift),
      .round_idx(a_idx), .hv_accum(a_hv_accum), .busy(a_busy),
      .digest_valid(a_dv), .digest_ready(a_dready)
`ifdef SHA256_CTRL_BLKCNT_EN
      , .blk_cnt(a_blk_cnt)
`endif
   );

   sha256_round_ctrl #(.ROUNDS(4), .IDX_W(2)) u_dut4 (
      .clk(clk), .reset(reset),
      .blk_valid(b_valid), .blk_first(b_first), .blk_last(b_last),
      .blk_ready(b_ready), .hv_init(b_hv_init), .wv_load(b_wv_load),
      .w_load(b_w_load), .wv_step(b_wv_step), .w_shift(b_w_shift),
      .round_idx(b_idx), .hv_accum(b_hv_accum), .busy(b_busy),
      .digest_valid(b_dv), .digest_ready(b_dready)
`ifdef SHA256_CTRL_BLKCNT_EN
      , .blk_cnt(b_blk_cnt)
`endif
   );

   logic [14:0] obs_a, obs_b;
   assign obs_a = {a_ready, a_hv_init, a_wv_load, a_w_load, a_wv_step, a_w_shift,
                   a_hv_accum, a_busy, a_dv, a_idx};
   assign obs_b = {b_ready, b_hv_init, b_wv_load, b_w_load, b_wv_step, b_w_shift,
                   b_hv_accum, b_busy, b_dv, 4'b0000, b_idx};

   typedef struct {
      int st;
      int idx;
   } exp_t;

   exp_t        sbq[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc    = 0;
   logic [31:0] bc_model = 32'd0;

   // Expected output vector for a given controller state and round index.
   function automatic logic [14:0] ev(input int st, input int idx);
      logic [14:0] v;
      logic [31:0] iv;
      v  = 15'd0;
      iv = idx;
      case (st)
         S_IDLE:  v[14] = 1'b1;
         S_INIT:  begin v[13] = 1'b1; v[7] = 1'b1; end
         S_LOAD:  begin v[12] = 1'b1; v[11] = 1'b1; v[7] = 1'b1; end
         S_ROUND: begin v[10] = 1'b1; v[9] = 1'b1; v[7] = 1'b1; v[5:0] = iv[5:0]; end
         S_ACCUM: begin v[8] = 1'b1; v[7] = 1'b1; end
         S_OUT:   begin v[6] = 1'b1; v[7] = 1'b1; end
         default: v = 15'h7fff;
      endcase
      return v;
   endfunction

   task automatic push(input int st, input int idx);
      exp_t e;
      e.st  = st;
      e.idx = idx;
      sbq.push_back(e);
   endtask

   task automatic drive(input bit sel, input bit v, input bit f, input bit l, input bit r);
      if (sel) begin
         b_valid = v; b_first = f; b_last = l; b_dready = r;
      end else begin
         a_valid = v; a_first = f; a_last = l; a_dready = r;
      end
   endtask

   task automatic set_valid(input bit sel, input bit v);
      if (sel) b_valid = v;
      else     a_valid = v;
   endtask

   task automatic set_ready(input bit sel, input bit r);
      if (sel) b_dready = r;
      else     a_dready = r;
   endtask

   // Pop one expected vector and compare against the selected instance.
   task automatic check_now(input bit sel, output int st_seen);
      exp_t        e;
      logic [14:0] exp_v;
      logic [14:0] obs_v;
      st_seen = -1;
      if (sbq.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL scoreboard_empty cyc=%0d", cyc);
      end else begin
         e     = sbq.pop_front();
         exp_v = ev(e.st, e.idx);
         obs_v = sel ? obs_b : obs_a;
         checks++;
         assert (obs_v === exp_v) else begin
            errors++;
            $error("FAIL %s cyc=%0d st=%0d observed=%h expected=%h",
                   sel ? "ctrl4" : "ctrl64", cyc, e.st, obs_v, exp_v);
         end
`ifdef SHA256_CTRL_BLKCNT_EN
         if (!sel) begin
            checks++;
            assert (a_blk_cnt === bc_model) else begin
               errors++;
               $error("FAIL blk_cnt cyc=%0d observed=%0d expected=%0d", cyc, a_blk_cnt, bc_model);
            end
            if (e.st == S_INIT) bc_model = 32'd0;
            else if (e.st == S_ACCUM && bc_model != 32'hffff_ffff) bc_model = bc_model + 32'd1;
         end
`endif
         st_seen = e.st;
      end
   endtask

   task automatic step(input bit sel, output int st_seen);
      @(posedge clk);
      cyc++;
      @(negedge clk);
      check_now(sel, st_seen);
   endtask

   // Drive one block (called at a falling edge with the instance in IDLE)
   // and check every cycle until it is back in IDLE. hold = OUT cycles.
   task automatic send_block(input bit sel, input bit first, input bit last,
                             input int hold, input bit keep_valid);
      int rounds;
      int st;
      int outs;
      rounds = sel ? 4 : 64;
      outs   = 0;
      if (first) push(S_INIT, 0);
      push(S_LOAD, 0);
      for (int i = 0; i < rounds; i++) push(S_ROUND, i);
      push(S_ACCUM, 0);
      if (last) begin
         for (int i = 0; i < hold; i++) push(S_OUT, 0);
      end
      push(S_IDLE, 0);
      drive(sel, 1'b1, first, last, (hold == 1));
      while (sbq.size() > 0) begin
         step(sel, st);
         if (!keep_valid) set_valid(sel, 1'b0);
         if (st == S_OUT) begin
            outs++;
            if (outs == hold) begin
               set_ready(sel, 1'b1);
               set_valid(sel, 1'b0);
            end
         end
      end
      drive(sel, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      int st;
      reset = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      // Reset state; a request while in reset must be ignored.
      a_valid = 1'b1; a_first = 1'b1;
      @(posedge clk);
      @(negedge clk);
      push(S_IDLE, 0); check_now(1'b0, st);
      push(S_IDLE, 0); check_now(1'b1, st);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;

      // 1: single-block message, digest_ready high throughout.
      send_block(1'b0, 1'b1, 1'b1, 1, 1'b0);

      // 2: two-block message: first then last.
      send_block(1'b0, 1'b1, 1'b0, 1, 1'b0);
      send_block(1'b0, 1'b0, 1'b1, 1, 1'b0);

      // 3: digest backpressure for 10 cycles, blk_valid held high throughout.
      send_block(1'b0, 1'b1, 1'b1, 10, 1'b1);

      // 4: reset asserted while round_idx = 30.
      push(S_INIT, 0);
      push(S_LOAD, 0);
      for (int i = 0; i <= 30; i++) push(S_ROUND, i);
      drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
      while (sbq.size() > 0) begin
         step(1'b0, st);
         a_valid = 1'b0;
      end
      reset = 1'b1;
      #1;
      bc_model = 32'd0;
      push(S_IDLE, 0); check_now(1'b0, st);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      push(S_IDLE, 0); check_now(1'b0, st);
      send_block(1'b0, 1'b1, 1'b1, 1, 1'b0);

      // 5: 4-round build, single block: digest_valid at c8.
      send_block(1'b1, 1'b1, 1'b1, 1, 1'b0);
      send_block(1'b1, 1'b1, 1'b1, 3, 1'b0);

      // 6: three-block message, then a new single-block message.
      send_block(1'b0, 1'b1, 1'b0, 1, 1'b0);
      send_block(1'b0, 1'b0, 1'b0, 1, 1'b0);
      send_block(1'b0, 1'b0, 1'b1, 2, 1'b0);
      send_block(1'b0, 1'b1, 1'b1, 1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
